hh_phase_modulator: RTL and testbench

- Downstream stage of the HitchHike MAC packet generator.
- Consumes the generator's `sending` / `head` / `datacmd` stream and converts it into the RF-switch drive for codeword-translation backscatter.
- The output is a square-wave frequency-shift carrier whose phase is differentially flipped once per 1 µs 802.11b symbol according to the tag data bit.
- During the header phase no flipping occurs, so the receiver can lock on an unmodified preamble.

---
 rtl/hh_phase_modulator.sv | 129 ++++++++++++
 tb/tb_hh_phase_modulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hh_phase_modulator.sv
// HitchHike phase modulator: turns the sending/head/datacmd stream into a differentially phase-flipped square-wave RF switch drive.
// Latency: burst starts one clock after sending is seen in IDLE; phase/rf_out update on the symbol-boundary edge.
// Backpressure: none; bit_req asks upstream for datacmd, which must be valid at the following boundary edge.
module hh_phase_modulator #(
    parameter int unsigned SYM_CLKS  = 10,
    parameter int unsigned SHIFT_DIV = 1,
    parameter int unsigned CW        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic sending,
    input  logic head,
    input  logic datacmd,
    output logic bit_req,
    output logic sym_strobe,
    output logic phase,
    output logic rf_out,
    output logic active
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [CW-1:0] SYM_LAST = CW'(SYM_CLKS - 1);
    localparam logic [CW-1:0] SYM_REQ  = CW'(SYM_CLKS - 2);
    localparam logic [CW-1:0] DIV_LAST = CW'(SHIFT_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] sym_cnt_q, sym_cnt_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          sq_q, sq_d;
    logic          phase_q, phase_d;
    logic          rf_q, rf_d;
    logic          active_q, active_d;

    logic boundary;
    logic div_wrap;
    logic busy;

    assign boundary = (sym_cnt_q == SYM_LAST);
    assign div_wrap = (div_cnt_q == DIV_LAST);
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        div_cnt_d = div_cnt_q;
        sq_d      = sq_q;
        phase_d   = phase_q;
        active_d  = active_q;
        rf_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sym_cnt_d = '0;
                div_cnt_d = '0;
                sq_d      = 1'b0;
                phase_d   = 1'b0;
                active_d  = 1'b0;
                if (sending) begin
                    state_d  = head ? ST_HEAD : ST_DATA;
                    active_d = 1'b1;
                end
            end
            ST_HEAD, ST_DATA: begin
                sym_cnt_d = boundary ? '0 : sym_cnt_q + CW'(1);
                // Oscillator free-runs across symbols to keep the carrier phase-coherent.
                div_cnt_d = div_wrap ? '0 : div_cnt_q + CW'(1);
                sq_d      = sq_q ^ div_wrap;
                if (boundary) begin
                    if (!sending) begin
                        state_d   = ST_IDLE;
                        sym_cnt_d = '0;
                        div_cnt_d = '0;
                        sq_d      = 1'b0;
                        phase_d   = 1'b0;
                        active_d  = 1'b0;
                    end else if (head) begin
                        state_d = ST_HEAD;
                    end else begin
                        state_d = ST_DATA;
                        phase_d = phase_q ^ datacmd;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sym_cnt_d = '0;
                div_cnt_d = '0;
                sq_d      = 1'b0;
                phase_d   = 1'b0;
                active_d  = 1'b0;
            end
        endcase

        // Registered so the switch drive never glitches on counter decode.
        if (state_d != ST_IDLE) begin
            rf_d = sq_d ^ phase_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
            div_cnt_q <= '0;
            sq_q      <= 1'b0;
            phase_q   <= 1'b0;
            rf_q      <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            div_cnt_q <= div_cnt_d;
            sq_q      <= sq_d;
            phase_q   <= phase_d;
            rf_q      <= rf_d;
            active_q  <= active_d;
        end
    end

    assign sym_strobe = busy && boundary;
    assign bit_req    = busy && (sym_cnt_q == SYM_REQ);
    assign phase      = phase_q;
    assign rf_out     = rf_q;
    assign active     = active_q;

endmodule

// File: tb/tb_hh_phase_modulator.sv
// Bench for hh_phase_modulator: directed sequences, a per-symbol vector table and randomized traffic
// checked against a burst-time model (outputs derived from elapsed clocks since burst start).
module tb_hh_phase_modulator;

    localparam int S  = 10;
    localparam int D1 = 1;
    localparam int D3 = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sending = 1'b0;
    logic head = 1'b0;
    logic datacmd = 1'b0;

    logic bit_req_a, sym_strobe_a, phase_a, rf_out_a, active_a;
    logic bit_req_b, sym_strobe_b, phase_b, rf_out_b, active_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    hh_phase_modulator #(.SYM_CLKS(S), .SHIFT_DIV(D1), .CW(8)) dut_a (
        .clock(clock), .reset(reset), .sending(sending), .head(head), .datacmd(datacmd),
        .bit_req(bit_req_a), .sym_strobe(sym_strobe_a), .phase(phase_a),
        .rf_out(rf_out_a), .active(active_a)
    );

    hh_phase_modulator #(.SYM_CLKS(S), .SHIFT_DIV(D3), .CW(8)) dut_b (
        .clock(clock), .reset(reset), .sending(sending), .head(head), .datacmd(datacmd),
        .bit_req(bit_req_b), .sym_strobe(sym_strobe_b), .phase(phase_b),
        .rf_out(rf_out_b), .active(active_b)
    );

    // Reference: a burst is just "clocks elapsed since start" plus an accumulated phase.
    logic m_busy  = 1'b0;
    int   m_t     = 0;
    logic m_phase = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_t = 0; m_phase = 1'b0;
        end else if (!m_busy) begin
            if (sending) begin
                m_busy = 1'b1; m_t = 0; m_phase = 1'b0;
            end
        end else if (m_t % S == S - 1) begin
            if (!sending) begin
                m_busy = 1'b0; m_t = 0; m_phase = 1'b0;
            end else begin
                if (!head) m_phase = m_phase ^ datacmd;
                m_t = m_t + 1;
            end
        end else begin
            m_t = m_t + 1;
        end
    end

    function automatic logic [4:0] model_out(input int div);
        logic sq;
        if (!m_busy) return 5'b0;
        sq = ((m_t / div) % 2) == 1;
        // {active, phase, rf_out, sym_strobe, bit_req}
        return {1'b1, m_phase, sq ^ m_phase, (m_t % S) == S - 1, (m_t % S) == S - 2};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {4'b0, act}, {4'b0, exp});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        chk("model_div1", {active_a, phase_a, rf_out_a, sym_strobe_a, bit_req_a}, model_out(D1));
        chk("model_div3", {active_b, phase_b, rf_out_b, sym_strobe_b, bit_req_b}, model_out(D3));
    endtask

    typedef struct {
        logic s;
        logic h;
        logic d;
        logic exp_phase;
        logic exp_active;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{s: 1'b1, h: 1'b0, d: 1'b1, exp_phase: 1'b1, exp_active: 1'b1};
        tbl[1] = '{s: 1'b1, h: 1'b0, d: 1'b0, exp_phase: 1'b1, exp_active: 1'b1};
        tbl[2] = '{s: 1'b1, h: 1'b0, d: 1'b1, exp_phase: 1'b0, exp_active: 1'b1};
        tbl[3] = '{s: 1'b1, h: 1'b0, d: 1'b1, exp_phase: 1'b1, exp_active: 1'b1};
        tbl[4] = '{s: 1'b1, h: 1'b1, d: 1'b1, exp_phase: 1'b1, exp_active: 1'b1};
        tbl[5] = '{s: 1'b0, h: 1'b0, d: 1'b1, exp_phase: 1'b0, exp_active: 1'b0};

        // Reset held with sending asserted: everything stays 0.
        #1;
        reset = 1'b1; sending = 1'b1; head = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_hold", {active_a, phase_a, rf_out_a, sym_strobe_a, bit_req_a}, 5'b0);
        end
        reset = 1'b0;
        step();
        chk1("active_after_release", active_a, 1'b1);

        // Header burst: rf toggles every clock, strobe/bit_req at fixed symbol positions.
        for (int k = 0; k < 30; k++) begin
            chk1("hdr_phase", phase_a, 1'b0);
            chk1("hdr_rf", rf_out_a, (k % 2) == 1);
            chk1("hdr_strobe", sym_strobe_a, (k % 10) == 9);
            chk1("hdr_bitreq", bit_req_a, (k % 10) == 8);
            chk1("hdr_rf_div3", rf_out_b, ((k / 3) % 2) == 1);
            step();
        end

        // Differential data encoding, one table row per symbol.
        for (int v = 0; v < 6; v++) begin
            sending = tbl[v].s; head = tbl[v].h; datacmd = tbl[v].d;
            for (int c = 0; c < S; c++) step();
            chk1("tbl_phase", phase_a, tbl[v].exp_phase);
            chk1("tbl_active", active_a, tbl[v].exp_active);
            if (tbl[v].exp_active && v < 4) chk1("tbl_rf_inverted", rf_out_a, tbl[v].exp_phase);
        end
        chk1("tbl_rf_idle", rf_out_a, 1'b0);

        // Mid-symbol drop of sending only takes effect at the boundary.
        sending = 1'b1; head = 1'b1;
        step();
        for (int c = 0; c < 4; c++) step();
        sending = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk1("drop_still_active", active_a, 1'b1);
        chk1("drop_strobe", sym_strobe_a, 1'b1);
        step();
        chk("drop_idle", {active_a, phase_a, rf_out_a}, 3'b000);

        // Asynchronous reset in the middle of a data symbol.
        sending = 1'b1; head = 1'b1;
        step();
        head = 1'b0; datacmd = 1'b1;
        for (int c = 0; c < S; c++) step();
        chk1("pre_rst_phase", phase_a, 1'b1);
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1;
        #1;
        chk("async_rst_a", {active_a, phase_a, rf_out_a, sym_strobe_a, bit_req_a}, 5'b0);
        chk("async_rst_b", {active_b, phase_b, rf_out_b, sym_strobe_b, bit_req_b}, 5'b0);
        reset = 1'b0; head = 1'b1;
        step();
        chk("restart", {active_a, phase_a, sym_strobe_a}, 3'b100);
        for (int c = 0; c < 9; c++) step();
        chk1("restart_strobe", sym_strobe_a, 1'b1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            sending = ($urandom_range(0, 29) != 0);
            head    = ($urandom_range(0, 3) == 0);
            datacmd = $urandom_range(0, 1) == 1;
            reset   = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
